param_queue: RTL and testbench

PARAM_QUEUE -- requirements
Module: param_queue

---
 rtl/param_queue.sv | 104 ++++++++++
 tb/tb_param_queue.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_queue.sv
// Parameterised synchronous FIFO with registered read data, occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module param_queue #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;
    logic             push_drop;
    logic             pop_drop;

    // Pointers wrap by explicit compare so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        pop_ok    = pop && !clear && (count != '0);
        push_ok   = push && !clear && ((count != CNT_MAX) || pop_ok);
        push_drop = push && !clear && !push_ok;
        pop_drop  = pop && !clear && (count == '0);
    end

    // Storage carries no reset; stale entries are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_next(rd_ptr);
                dout   <= mem[rd_ptr];
            end
            dout_valid <= pop_ok;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_drop) begin
                overflow <= 1'b1;
            end
            if (pop_drop) begin
                underflow <= 1'b1;
            end
        end
    end

    assign empty        = (count == '0);
    assign full         = (count == CNT_MAX);
    assign almost_empty = (count <= AE_CNT);
    assign almost_full  = (count >= AF_CNT);

endmodule

// File: tb/tb_param_queue.sv
// Directed, table-driven bench for param_queue: a DEPTH=8 instance and a
// DEPTH=5 instance share stimulus; each table is checked against one of them.
module tb_param_queue;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       push;
    logic       pop;
    logic [3:0] din;

    logic [3:0] dout;
    logic       dout_valid;
    logic [3:0] count;
    logic       empty, full, almost_empty, almost_full, overflow, underflow;

    logic [3:0] dout5;
    logic       dout_valid5;
    logic [2:0] count5;
    logic       empty5, full5, almost_empty5, almost_full5, overflow5, underflow5;

    logic [14:0] obs8;
    logic [14:0] obs5;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       clr;
        logic       psh;
        logic       pp;
        logic [3:0] din;
        logic [3:0] dout;
        logic       dv;
        logic [3:0] cnt;
        logic [3:0] flg;   // {empty, full, almost_empty, almost_full}
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t tab[$];

    param_queue #(.WIDTH(4), .DEPTH(8)) dut (
        .clk(clk), .reset(reset), .clear(clear), .push(push), .pop(pop), .din(din),
        .dout(dout), .dout_valid(dout_valid), .count(count),
        .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
        .overflow(overflow), .underflow(underflow)
    );

    param_queue #(.WIDTH(4), .DEPTH(5)) dut5 (
        .clk(clk), .reset(reset), .clear(clear), .push(push), .pop(pop), .din(din),
        .dout(dout5), .dout_valid(dout_valid5), .count(count5),
        .empty(empty5), .full(full5), .almost_empty(almost_empty5), .almost_full(almost_full5),
        .overflow(overflow5), .underflow(underflow5)
    );

    assign obs8 = {dout, dout_valid, count, empty, full, almost_empty, almost_full,
                   overflow, underflow};
    assign obs5 = {dout5, dout_valid5, 1'b0, count5, empty5, full5, almost_empty5,
                   almost_full5, overflow5, underflow5};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic add(input logic c, input logic p, input logic q, input logic [3:0] d,
                       input logic [3:0] o, input logic v, input logic [3:0] n,
                       input logic [3:0] f, input logic ov, input logic un);
        vec_t t;
        t.clr = c; t.psh = p; t.pp = q; t.din = d;
        t.dout = o; t.dv = v; t.cnt = n; t.flg = f; t.ovf = ov; t.udf = un;
        tab.push_back(t);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [14:0] act, input logic [14:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s #%0d: got dout=%h vld=%b cnt=%0d flags(e,f,ae,af)=%b ovf=%b udf=%b; expected dout=%h vld=%b cnt=%0d flags=%b ovf=%b udf=%b",
                     name, idx, act[14:11], act[10], act[9:6], act[5:2], act[1], act[0],
                     exp[14:11], exp[10], exp[9:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic run_table(input string name, input bit use5);
        for (int i = 0; i < tab.size(); i++) begin
            @(negedge clk);
            clear = tab[i].clr;
            push  = tab[i].psh;
            pop   = tab[i].pp;
            din   = tab[i].din;
            @(posedge clk);
            #1;
            check(name, i, use5 ? obs5 : obs8,
                  {tab[i].dout, tab[i].dv, tab[i].cnt, tab[i].flg, tab[i].ovf, tab[i].udf});
        end
    endtask

    initial begin
        reset = 1'b0;
        clear = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        din   = 4'h0;
        #1;
        check("reset_state", 0, obs8, {4'h0, 1'b0, 4'd0, 4'b1010, 1'b0, 1'b0});
        repeat (2) @(negedge clk);
        reset = 1'b1;

        //   clr psh pop din   dout  dv cnt   flags    ovf udf
        // Pop on empty, then clear
        add(0, 0, 1, 4'h0, 4'h0, 0, 4'd0, 4'b1010, 0, 1);
        add(1, 0, 0, 4'h0, 4'h0, 0, 4'd0, 4'b1010, 0, 0);
        // Push A, C; pop twice; idle holds dout
        add(0, 1, 0, 4'hA, 4'h0, 0, 4'd1, 4'b0010, 0, 0);
        add(0, 1, 0, 4'hC, 4'h0, 0, 4'd2, 4'b0010, 0, 0);
        add(0, 0, 1, 4'h0, 4'hA, 1, 4'd1, 4'b0010, 0, 0);
        add(0, 0, 1, 4'h0, 4'hC, 1, 4'd0, 4'b1010, 0, 0);
        add(0, 0, 0, 4'h0, 4'hC, 0, 4'd0, 4'b1010, 0, 0);
        // Fill with 0..7, overflow push of F, drain
        add(0, 1, 0, 4'h0, 4'hC, 0, 4'd1, 4'b0010, 0, 0);
        add(0, 1, 0, 4'h1, 4'hC, 0, 4'd2, 4'b0010, 0, 0);
        add(0, 1, 0, 4'h2, 4'hC, 0, 4'd3, 4'b0000, 0, 0);
        add(0, 1, 0, 4'h3, 4'hC, 0, 4'd4, 4'b0000, 0, 0);
        add(0, 1, 0, 4'h4, 4'hC, 0, 4'd5, 4'b0000, 0, 0);
        add(0, 1, 0, 4'h5, 4'hC, 0, 4'd6, 4'b0001, 0, 0);
        add(0, 1, 0, 4'h6, 4'hC, 0, 4'd7, 4'b0001, 0, 0);
        add(0, 1, 0, 4'h7, 4'hC, 0, 4'd8, 4'b0101, 0, 0);
        add(0, 1, 0, 4'hF, 4'hC, 0, 4'd8, 4'b0101, 1, 0);
        add(0, 0, 1, 4'h0, 4'h0, 1, 4'd7, 4'b0001, 1, 0);
        add(0, 0, 1, 4'h0, 4'h1, 1, 4'd6, 4'b0001, 1, 0);
        add(0, 0, 1, 4'h0, 4'h2, 1, 4'd5, 4'b0000, 1, 0);
        add(0, 0, 1, 4'h0, 4'h3, 1, 4'd4, 4'b0000, 1, 0);
        add(0, 0, 1, 4'h0, 4'h4, 1, 4'd3, 4'b0000, 1, 0);
        add(0, 0, 1, 4'h0, 4'h5, 1, 4'd2, 4'b0010, 1, 0);
        add(0, 0, 1, 4'h0, 4'h6, 1, 4'd1, 4'b0010, 1, 0);
        add(0, 0, 1, 4'h0, 4'h7, 1, 4'd0, 4'b1010, 1, 0);
        add(1, 0, 0, 4'h0, 4'h7, 0, 4'd0, 4'b1010, 0, 0);
        // Wrap: push 6, pop 6, push 1..8
        add(0, 1, 0, 4'h9, 4'h7, 0, 4'd1, 4'b0010, 0, 0);
        add(0, 1, 0, 4'hA, 4'h7, 0, 4'd2, 4'b0010, 0, 0);
        add(0, 1, 0, 4'hB, 4'h7, 0, 4'd3, 4'b0000, 0, 0);
        add(0, 1, 0, 4'hC, 4'h7, 0, 4'd4, 4'b0000, 0, 0);
        add(0, 1, 0, 4'hD, 4'h7, 0, 4'd5, 4'b0000, 0, 0);
        add(0, 1, 0, 4'hE, 4'h7, 0, 4'd6, 4'b0001, 0, 0);
        add(0, 0, 1, 4'h0, 4'h9, 1, 4'd5, 4'b0000, 0, 0);
        add(0, 0, 1, 4'h0, 4'hA, 1, 4'd4, 4'b0000, 0, 0);
        add(0, 0, 1, 4'h0, 4'hB, 1, 4'd3, 4'b0000, 0, 0);
        add(0, 0, 1, 4'h0, 4'hC, 1, 4'd2, 4'b0010, 0, 0);
        add(0, 0, 1, 4'h0, 4'hD, 1, 4'd1, 4'b0010, 0, 0);
        add(0, 0, 1, 4'h0, 4'hE, 1, 4'd0, 4'b1010, 0, 0);
        add(0, 1, 0, 4'h1, 4'hE, 0, 4'd1, 4'b0010, 0, 0);
        add(0, 1, 0, 4'h2, 4'hE, 0, 4'd2, 4'b0010, 0, 0);
        add(0, 1, 0, 4'h3, 4'hE, 0, 4'd3, 4'b0000, 0, 0);
        add(0, 1, 0, 4'h4, 4'hE, 0, 4'd4, 4'b0000, 0, 0);
        add(0, 1, 0, 4'h5, 4'hE, 0, 4'd5, 4'b0000, 0, 0);
        add(0, 1, 0, 4'h6, 4'hE, 0, 4'd6, 4'b0001, 0, 0);
        add(0, 1, 0, 4'h7, 4'hE, 0, 4'd7, 4'b0001, 0, 0);
        add(0, 1, 0, 4'h8, 4'hE, 0, 4'd8, 4'b0101, 0, 0);
        // Full with push 9 and pop together, then drain
        add(0, 1, 1, 4'h9, 4'h1, 1, 4'd8, 4'b0101, 0, 0);
        add(0, 0, 1, 4'h0, 4'h2, 1, 4'd7, 4'b0001, 0, 0);
        add(0, 0, 1, 4'h0, 4'h3, 1, 4'd6, 4'b0001, 0, 0);
        add(0, 0, 1, 4'h0, 4'h4, 1, 4'd5, 4'b0000, 0, 0);
        add(0, 0, 1, 4'h0, 4'h5, 1, 4'd4, 4'b0000, 0, 0);
        add(0, 0, 1, 4'h0, 4'h6, 1, 4'd3, 4'b0000, 0, 0);
        add(0, 0, 1, 4'h0, 4'h7, 1, 4'd2, 4'b0010, 0, 0);
        add(0, 0, 1, 4'h0, 4'h8, 1, 4'd1, 4'b0010, 0, 0);
        add(0, 0, 1, 4'h0, 4'h9, 1, 4'd0, 4'b1010, 0, 0);
        // Empty with push and pop together; clear ignores push/pop
        add(0, 1, 1, 4'h5, 4'h9, 0, 4'd1, 4'b0010, 0, 1);
        add(1, 1, 1, 4'h6, 4'h9, 0, 4'd0, 4'b1010, 0, 0);
        // Build up count 5 for the asynchronous reset check
        add(0, 1, 0, 4'h1, 4'h9, 0, 4'd1, 4'b0010, 0, 0);
        add(0, 1, 0, 4'h2, 4'h9, 0, 4'd2, 4'b0010, 0, 0);
        add(0, 1, 0, 4'h3, 4'h9, 0, 4'd3, 4'b0000, 0, 0);
        add(0, 1, 0, 4'h4, 4'h9, 0, 4'd4, 4'b0000, 0, 0);
        add(0, 1, 0, 4'h5, 4'h9, 0, 4'd5, 4'b0000, 0, 0);
        run_table("depth8", 1'b0);

        // Reset mid-burst, between clock edges
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", 0, obs8, {4'h0, 1'b0, 4'd0, 4'b1010, 1'b0, 1'b0});
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
        @(posedge clk);
        #1;
        check("reset_held", 0, obs8, {4'h0, 1'b0, 4'd0, 4'b1010, 1'b0, 1'b0});
        @(negedge clk);
        reset = 1'b1;

        // DEPTH=5 (almost_full at 3): wrap and overflow
        tab.delete();
        add(0, 1, 0, 4'h1, 4'h0, 0, 4'd1, 4'b0010, 0, 0);
        add(0, 1, 0, 4'h2, 4'h0, 0, 4'd2, 4'b0010, 0, 0);
        add(0, 1, 0, 4'h3, 4'h0, 0, 4'd3, 4'b0001, 0, 0);
        add(0, 0, 1, 4'h0, 4'h1, 1, 4'd2, 4'b0010, 0, 0);
        add(0, 0, 1, 4'h0, 4'h2, 1, 4'd1, 4'b0010, 0, 0);
        add(0, 0, 1, 4'h0, 4'h3, 1, 4'd0, 4'b1010, 0, 0);
        add(0, 1, 0, 4'h1, 4'h3, 0, 4'd1, 4'b0010, 0, 0);
        add(0, 1, 0, 4'h2, 4'h3, 0, 4'd2, 4'b0010, 0, 0);
        add(0, 1, 0, 4'h3, 4'h3, 0, 4'd3, 4'b0001, 0, 0);
        add(0, 1, 0, 4'h4, 4'h3, 0, 4'd4, 4'b0001, 0, 0);
        add(0, 1, 0, 4'h5, 4'h3, 0, 4'd5, 4'b0101, 0, 0);
        add(0, 1, 0, 4'h6, 4'h3, 0, 4'd5, 4'b0101, 1, 0);
        add(0, 0, 1, 4'h0, 4'h1, 1, 4'd4, 4'b0001, 1, 0);
        add(0, 0, 1, 4'h0, 4'h2, 1, 4'd3, 4'b0001, 1, 0);
        add(0, 0, 1, 4'h0, 4'h3, 1, 4'd2, 4'b0010, 1, 0);
        add(0, 0, 1, 4'h0, 4'h4, 1, 4'd1, 4'b0010, 1, 0);
        add(0, 0, 1, 4'h0, 4'h5, 1, 4'd0, 4'b1010, 1, 0);
        run_table("depth5", 1'b1);

        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
